// File: rtl/audio_codec_i2s_if.sv
// Data-block side of the I2S codec: sample pacing strobes and the DAC/ADC sample words.
interface audio_codec_i2s_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic                sample_req;
  logic                sample_end;
  logic [SAMPLE_W-1:0] audio_output;
  logic [SAMPLE_W-1:0] audio_input;
  logic [1:0]          channel_sel;

  modport master (
    output sample_req,
    output sample_end,
    output audio_input,
    input  audio_output,
    input  channel_sel
  );

  modport slave (
    input  sample_req,
    input  sample_end,
    input  audio_input,
    output audio_output,
    output channel_sel
  );
endinterface

// File: rtl/audio_codec_i2s.sv
// I2S master: BCLK/LRCK generation, DAC serializer and ADC deserializer, one stereo frame per sample.
// Define CODEC_ADC_MIX_EN to report (left + right) >>> 1 instead of the left ADC word.
module audio_codec_i2s #(
  parameter int unsigned BCLK_HALF = 2,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned SAMPLE_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  audio_codec_i2s_if.master     bus,
  output logic                  AUD_BCLK,
  output logic                  AUD_DACLRCK,
  output logic                  AUD_ADCLRCK,
  output logic                  AUD_DACDAT,
  input  logic                  AUD_ADCDAT
);

  localparam int unsigned NSLOT  = 2 * SLOT_BITS;
  localparam int unsigned SLOT_W = $clog2(NSLOT);
  localparam int unsigned DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [SLOT_W-1:0] S_LAST   = SLOT_W'(NSLOT - 1);
  localparam logic [SLOT_W-1:0] S_REQ    = SLOT_W'(NSLOT - 2);
  localparam logic [SLOT_W-1:0] S_RIGHT  = SLOT_W'(SLOT_BITS);
  localparam logic [SLOT_W-1:0] L_FIRST  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] L_LAST   = SLOT_W'(SAMPLE_W);
  localparam logic [SLOT_W-1:0] R_FIRST  = SLOT_W'(SLOT_BITS + 1);
  localparam logic [SLOT_W-1:0] R_LAST   = SLOT_W'(SLOT_BITS + SAMPLE_W);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                lrck_q, lrck_d;
  logic                dacdat_q, dacdat_d;
  logic [SAMPLE_W-1:0] tx_l_q, tx_l_d;
  logic [SAMPLE_W-1:0] tx_r_q, tx_r_d;
  logic [SAMPLE_W-1:0] rx_l_q, rx_l_d;
  logic                done_q, done_d;
  logic                req_q, req_d;
  logic                end_q, end_d;
  logic [SAMPLE_W-1:0] ai_q, ai_d;

  logic                div_wrap;
  logic                bclk_rise;
  logic                bclk_fall;
  logic [SLOT_W-1:0]   slot_nxt;

`ifdef CODEC_ADC_MIX_EN
  logic [SAMPLE_W-1:0]        rx_r_q, rx_r_d;
  logic signed [SAMPLE_W:0]   mix_sum;

  always_comb begin
    mix_sum = {rx_l_q[SAMPLE_W-1], rx_l_q} + {rx_r_q[SAMPLE_W-1], rx_r_q};
  end
`endif

  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    bclk_fall = div_wrap & bclk_q;
    bclk_rise = div_wrap & ~bclk_q;
    slot_nxt  = (slot_q == S_LAST) ? '0 : slot_q + 1'b1;
  end

  always_comb begin
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    bclk_d   = bclk_q ^ div_wrap;
    slot_d   = slot_q;
    lrck_d   = lrck_q;
    dacdat_d = dacdat_q;
    tx_l_d   = tx_l_q;
    tx_r_d   = tx_r_q;
    rx_l_d   = rx_l_q;
`ifdef CODEC_ADC_MIX_EN
    rx_r_d   = rx_r_q;
`endif
    done_d   = 1'b0;
    req_d    = 1'b0;
    end_d    = 1'b0;
    ai_d     = ai_q;

    // Slot boundaries: everything the DAC side drives changes on the BCLK falling edge.
    if (bclk_fall) begin
      slot_d   = slot_nxt;
      lrck_d   = (slot_nxt >= S_RIGHT);
      req_d    = (slot_nxt == S_REQ);
      dacdat_d = 1'b0;
      if (slot_nxt == '0) begin
        tx_l_d = bus.channel_sel[0] ? bus.audio_output : '0;
        tx_r_d = bus.channel_sel[1] ? bus.audio_output : '0;
      end else if (slot_nxt >= L_FIRST && slot_nxt <= L_LAST) begin
        dacdat_d = tx_l_q[SAMPLE_W-1];
        tx_l_d   = {tx_l_q[SAMPLE_W-2:0], 1'b0};
      end else if (slot_nxt >= R_FIRST && slot_nxt <= R_LAST) begin
        dacdat_d = tx_r_q[SAMPLE_W-1];
        tx_r_d   = {tx_r_q[SAMPLE_W-2:0], 1'b0};
      end
    end

    if (bclk_rise) begin
      if (slot_q >= L_FIRST && slot_q <= L_LAST) begin
        rx_l_d = {rx_l_q[SAMPLE_W-2:0], AUD_ADCDAT};
`ifndef CODEC_ADC_MIX_EN
        done_d = (slot_q == L_LAST);
`endif
      end
`ifdef CODEC_ADC_MIX_EN
      if (slot_q >= R_FIRST && slot_q <= R_LAST) begin
        rx_r_d = {rx_r_q[SAMPLE_W-2:0], AUD_ADCDAT};
        done_d = (slot_q == R_LAST);
      end
`endif
    end

    // Word is complete in the capture register one clk after its LSB edge.
    if (done_q) begin
      end_d = 1'b1;
`ifdef CODEC_ADC_MIX_EN
      ai_d  = SAMPLE_W'(mix_sum >>> 1);
`else
      ai_d  = rx_l_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      slot_q   <= '0;
      lrck_q   <= 1'b0;
      dacdat_q <= 1'b0;
      tx_l_q   <= '0;
      tx_r_q   <= '0;
      rx_l_q   <= '0;
`ifdef CODEC_ADC_MIX_EN
      rx_r_q   <= '0;
`endif
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      end_q    <= 1'b0;
      ai_q     <= '0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      slot_q   <= slot_d;
      lrck_q   <= lrck_d;
      dacdat_q <= dacdat_d;
      tx_l_q   <= tx_l_d;
      tx_r_q   <= tx_r_d;
      rx_l_q   <= rx_l_d;
`ifdef CODEC_ADC_MIX_EN
      rx_r_q   <= rx_r_d;
`endif
      done_q   <= done_d;
      req_q    <= req_d;
      end_q    <= end_d;
      ai_q     <= ai_d;
    end
  end

  assign bus.sample_req  = req_q;
  assign bus.sample_end  = end_q;
  assign bus.audio_input = ai_q;
  assign AUD_BCLK        = bclk_q;
  assign AUD_DACLRCK     = lrck_q;
  assign AUD_ADCLRCK     = lrck_q;
  assign AUD_DACDAT      = dacdat_q;

endmodule

// File: tb/tb_audio_codec_i2s.sv
// Bench for audio_codec_i2s: frame-timing model derived from the clk count since reset release.
module tb_audio_codec_i2s;
  localparam int H  = 2;
  localparam int SB = 32;
  localparam int SW = 16;
  localparam int TS = 2 * H;
  localparam int F  = 2 * SB * TS;
  localparam int NF = 8;
`ifdef CODEC_ADC_MIX_EN
  localparam int END_POS = (SB + SW) * TS + H + 1;
  localparam logic [15:0] FIRST_AI = 16'hC91A;
`else
  localparam int END_POS = SW * TS + H + 1;
  localparam logic [15:0] FIRST_AI = 16'h8001;
`endif

  logic clk = 1'b0;
  logic reset;
  logic bclk, dlrck, alrck, dacdat, adcdat;

  always #5 clk = ~clk;

  audio_codec_i2s_if #(.SAMPLE_W(SW)) bus ();

  audio_codec_i2s #(.BCLK_HALF(H), .SLOT_BITS(SB), .SAMPLE_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .AUD_BCLK    (bclk),
    .AUD_DACLRCK (dlrck),
    .AUD_ADCLRCK (alrck),
    .AUD_DACDAT  (dacdat),
    .AUD_ADCDAT  (adcdat)
  );

  // Per-frame stimulus, indexed by frame number since the last reset release.
  logic [15:0] dac_tab [NF] = '{16'h0000, 16'hA5C3, 16'hFFFF, 16'h1234,
                                16'h8000, 16'h0F0F, 16'h0000, 16'h0000};
  logic [1:0]  sel_tab [NF] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11};
  logic [15:0] adc_l   [NF] = '{16'h8001, 16'h7FFF, 16'hFFFF, 16'h0000,
                                16'h5555, 16'h1357, 16'h0F00, 16'h0001};
  logic [15:0] adc_r   [NF] = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000,
                                16'hAAAA, 16'h2468, 16'hF00F, 16'h0002};

  int errors = 0;
  int checks = 0;
  int n;

  always @(posedge clk or posedge reset)
    if (reset) n <= 0;
    else       n <= n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
    end
  endtask

  function automatic int idx(input int f);
    return (f > NF - 1) ? NF - 1 : f;
  endfunction

  function automatic logic adc_bit(input int f, input int s);
    logic [15:0] w;
    if (s >= 1 && s <= SW) begin
      w = adc_l[idx(f)];
      return w[SW - s];
    end
    if (s >= SB + 1 && s <= SB + SW) begin
      w = adc_r[idx(f)];
      return w[SB + SW - s];
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_adc(input int f);
    int l, r;
    l = $signed(adc_l[f]);
    r = $signed(adc_r[f]);
`ifdef CODEC_ADC_MIX_EN
    return 16'((l + r) >>> 1);
`else
    return 16'(l + 0 * r);
`endif
  endfunction

  // Input driver: ADC bits follow the slot grid; DAC word/channel select change at chosen points.
  initial begin
    int fr, pos;
    adcdat           = 1'b1;
    bus.audio_output = 16'hDEAD;
    bus.channel_sel  = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        fr  = n / F;
        pos = n % F;
        adcdat = adc_bit(fr, pos / TS);
        if (pos == 5 * TS)      bus.channel_sel  = sel_tab[idx(fr + 1)];
        if (pos == 6 * TS)      bus.audio_output = 16'hDEAD;
        if (pos == F - 2*TS + 1) bus.audio_output = dac_tab[idx(fr + 1)];
      end
    end
  end

  logic [15:0] exp_ai;
  logic [15:0] wl, wr, cap_l, cap_r;
  logic        e_dac, e_bclk, e_lrck, e_req, e_end;
  int          fr, pos, s, last_req, last_end;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      exp_ai   = '0;
      last_req = -1;
      last_end = -1;
      chk("rst_bclk",   32'(bclk), 0);
      chk("rst_dlrck",  32'(dlrck), 0);
      chk("rst_alrck",  32'(alrck), 0);
      chk("rst_dacdat", 32'(dacdat), 0);
      chk("rst_req",    32'(bus.sample_req), 0);
      chk("rst_end",    32'(bus.sample_end), 0);
      chk("rst_ai",     32'(bus.audio_input), 0);
    end else begin
      fr  = n / F;
      pos = n % F;
      s   = pos / TS;
      if (fr == 0) begin
        wl = '0;
        wr = '0;
      end else begin
        wl = sel_tab[idx(fr)][0] ? dac_tab[idx(fr)] : 16'h0000;
        wr = sel_tab[idx(fr)][1] ? dac_tab[idx(fr)] : 16'h0000;
      end
      e_dac = 1'b0;
      if (s >= 1 && s <= SW)                e_dac = wl[SW - s];
      else if (s >= SB + 1 && s <= SB + SW) e_dac = wr[SB + SW - s];
      e_bclk = ((pos % TS) >= H);
      e_lrck = (s >= SB);
      e_req  = (pos == (2*SB - 2) * TS);
      e_end  = (pos == END_POS);
      if (e_end) exp_ai = model_adc(idx(fr));

      chk("bclk",   32'(bclk), 32'(e_bclk));
      chk("dlrck",  32'(dlrck), 32'(e_lrck));
      chk("alrck",  32'(alrck), 32'(e_lrck));
      chk("dacdat", 32'(dacdat), 32'(e_dac));
      chk("req",    32'(bus.sample_req), 32'(e_req));
      chk("end",    32'(bus.sample_end), 32'(e_end));
      chk("ai",     32'(bus.audio_input), 32'(exp_ai));

      // Hand-computed anchors for the model.
      if (n == H - 1) chk("bclk_pre_rise", 32'(bclk), 0);
      if (n == H)     chk("bclk_first_rise", 32'(bclk), 1);
      if (e_end && fr == 0) chk("first_ai_literal", 32'(bus.audio_input), 32'(FIRST_AI));
      if (bus.sample_req) begin
        if (last_req >= 0) chk("req_period", n - last_req, 256);
        last_req = n;
      end
      if (bus.sample_end) begin
        if (last_end >= 0) chk("end_period", n - last_end, 256);
        last_end = n;
      end
      if ((pos % TS) == H) begin
        if (s >= 1 && s <= SW)           cap_l = {cap_l[14:0], dacdat};
        if (s >= SB + 1 && s <= SB + SW) cap_r = {cap_r[14:0], dacdat};
        if (s == 2*SB - 1 && fr == 1) begin
          chk("dac_f1_left",  32'(cap_l), 32'h0000A5C3);
          chk("dac_f1_right", 32'(cap_r), 32'h0000A5C3);
        end
        if (s == 2*SB - 1 && fr == 2) begin
          chk("dac_f2_left",  32'(cap_l), 32'h0000FFFF);
          chk("dac_f2_right", 32'(cap_r), 32'h00000000);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    // Run into slot 20 of frame 5 with BCLK high, then reset asynchronously.
    repeat (5*F + 20*TS + 2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("mid_rst_bclk",   32'(bclk), 0);
    chk("mid_rst_dlrck",  32'(dlrck), 0);
    chk("mid_rst_alrck",  32'(alrck), 0);
    chk("mid_rst_dacdat", 32'(dacdat), 0);
    chk("mid_rst_req",    32'(bus.sample_req), 0);
    chk("mid_rst_end",    32'(bus.sample_end), 0);
    chk("mid_rst_ai",     32'(bus.audio_input), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3*F + 8) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
